// File: rtl/irq_controller.sv
// Eight-line falling-edge interrupt controller, fixed priority (line 7 highest), one request presented at a time.
// Latency: request sampled low at edge N is pending after N and presented (irq) after N+1; all outputs registered.
// Backpressure: a presented vector is held until ack, then until eoi; no re-arbitration or nesting meanwhile.
module irq_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_n,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [2:0] vector,
    output logic       busy,
    output logic [7:0] pending,
    output logic [7:0] mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] req_q;
    logic [7:0] edges;
    logic [7:0] eligible;
    logic [7:0] ack_clr;
    logic [2:0] winner;
    logic       any_eligible;
    logic       take_ack;

    // Arbitration and handshake decode from registered state only.
    always_comb begin
        edges        = req_q & ~req_n;
        eligible     = pending & ~mask;
        any_eligible = |eligible;
        winner       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
        take_ack = (state == ASSERT) && ack;
        ack_clr  = take_ack ? (8'b0000_0001 << vector) : 8'b0000_0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_eligible) state_nxt = ASSERT;
            ASSERT:  if (ack)          state_nxt = SERVICE;
            SERVICE: if (eoi)          state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq  = (state == ASSERT);
        busy = (state == SERVICE);
    end

    // A new edge on the acknowledged line wins over the ack clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 8'h00;
            pending <= 8'h00;
            mask    <= 8'h00;
            vector  <= 3'd0;
        end else begin
            req_q   <= req_n;
            pending <= (pending & ~ack_clr) | edges;
            if (mask_we) begin
                mask <= mask_in;
            end
            if (state == IDLE && any_eligible) begin
                vector <= winner;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios followed by randomized traffic against a line-level reference model.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_n;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] vector;
    logic       busy;
    logic [7:0] pending;
    logic [7:0] mask;

    always #5 clk = ~clk;

    irq_controller dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ack     (ack),
        .eoi     (eoi),
        .irq     (irq),
        .vector  (vector),
        .busy    (busy),
        .pending (pending),
        .mask    (mask)
    );

    typedef struct packed {
        logic       irq;
        logic [2:0] vector;
        logic       busy;
        logic [7:0] pending;
        logic [7:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: per-line pending/mask flags, previous line levels,
    // and whether a request is being presented or served.
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    bit         m_presenting;
    bit         m_serving;
    int         m_cur;

    task automatic step(input logic r, input logic [7:0] rq, input logic mwe,
                        input logic [7:0] mi, input logic a, input logic e);
        logic [7:0] nxt_pend;
        bit         found;
        exp_t       x;
        @(negedge clk);
        rst     = r;
        req_n   = rq;
        mask_we = mwe;
        mask_in = mi;
        ack     = a;
        eoi     = e;
        if (r) begin
            m_pend       = 8'h00;
            m_mask       = 8'h00;
            m_prev       = 8'h00;
            m_presenting = 0;
            m_serving    = 0;
            m_cur        = 0;
        end else begin
            nxt_pend = m_pend;
            if (m_presenting && a) nxt_pend[m_cur] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (m_prev[i] && !rq[i]) nxt_pend[i] = 1'b1;
            end
            if (!m_presenting && !m_serving) begin
                found = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (!found && m_pend[i] && !m_mask[i]) begin
                        m_cur        = i;
                        m_presenting = 1;
                        found        = 1;
                    end
                end
            end else if (m_presenting && a) begin
                m_presenting = 0;
                m_serving    = 1;
            end else if (m_serving && e) begin
                m_serving = 0;
            end
            m_pend = nxt_pend;
            if (mwe) m_mask = mi;
            m_prev = rq;
        end
        x.irq     = m_presenting;
        x.vector  = m_cur[2:0];
        x.busy    = m_serving;
        x.pending = m_pend;
        x.mask    = m_mask;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic [7:0] rq, input logic a, input logic e);
        step(1'b0, rq, 1'b0, 8'h00, a, e);
    endtask

    task automatic setmask(input logic [7:0] rq, input logic [7:0] m);
        step(1'b0, rq, 1'b1, m, 1'b0, 1'b0);
    endtask

    // Idle (arbitration) cycle, ack cycle, eoi cycle.
    task automatic serve(input logic [7:0] rq);
        cyc(rq, 1'b0, 1'b0);
        cyc(rq, 1'b1, 1'b0);
        cyc(rq, 1'b0, 1'b1);
    endtask

    // Monitor: the DUT presents registered outputs once per edge.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {irq, vector, busy, pending, mask};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got irq=%b vec=%0d busy=%b pend=%h mask=%h want irq=%b vec=%0d busy=%b pend=%h mask=%h",
                             $time, act.irq, act.vector, act.busy, act.pending, act.mask,
                             e.irq, e.vector, e.busy, e.pending, e.mask);
                end
            end
        end
    end

    initial begin
        logic [7:0] rq;
        rst = 1'b1; req_n = 8'hFF; mask_we = 1'b0; mask_in = 8'h00; ack = 1'b0; eoi = 1'b0;

        step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 8'h5A, 1'b1, 1'b1);

        // Single request on line 2
        cyc(8'hFF, 0, 0);
        cyc(8'hFB, 0, 0);
        serve(8'hFB);
        cyc(8'hFF, 0, 0);

        // Priority: lines 1, 5, 6 together
        cyc(8'h9D, 0, 0);
        repeat (3) serve(8'h9D);
        cyc(8'hFF, 0, 0);

        // Mask line 6, raise 6 and 3
        setmask(8'hFF, 8'h40);
        cyc(8'hB7, 0, 0);
        serve(8'hB7);
        cyc(8'hB7, 0, 0);
        cyc(8'hB7, 0, 0);
        setmask(8'hB7, 8'h00);
        serve(8'hB7);
        cyc(8'hFF, 0, 0);

        // No preemption: line 7 arrives while line 2 is presented
        cyc(8'hFB, 0, 0);
        cyc(8'hFB, 0, 0);
        cyc(8'h7B, 0, 0);
        cyc(8'h7B, 1, 0);
        cyc(8'h7B, 0, 1);
        serve(8'h7B);
        cyc(8'hFF, 0, 0);

        // Re-request on line 4 coinciding with its ack
        cyc(8'hEF, 0, 0);
        cyc(8'hEF, 0, 0);
        cyc(8'hFF, 0, 0);
        cyc(8'hEF, 1, 0);
        cyc(8'hEF, 0, 1);
        serve(8'hEF);
        cyc(8'hFF, 0, 0);

        // Reset in service with lines 5 and 0 pending
        cyc(8'h7F, 0, 0);
        cyc(8'h7F, 0, 0);
        cyc(8'h5E, 1, 0);
        cyc(8'h5E, 0, 0);
        step(1'b1, 8'h5E, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(8'hFF, 1, 0);
        cyc(8'hFF, 0, 1);
        cyc(8'hFF, 0, 0);

        // Randomized traffic
        rq = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            end
            step(($urandom_range(199) == 0), rq, ($urandom_range(15) == 0),
                 8'($urandom_range(255) & $urandom_range(255)),
                 ($urandom_range(2) == 0), ($urandom_range(2) == 0));
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
